// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings: instruction memory port,
// decode-side redirect/stall controls and the IF/ID register outputs.
interface fetch_stage_if;
  logic [31:0] pc;
  logic [31:0] imem_do;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [25:0] jmp_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    output pc, id_instr, id_pc4, id_valid, fault, fault_pc, fetch_count,
    input  imem_do, stall, br_taken, br_target, jmp, jmp_index, jr, jr_target
  );

  modport slave (
    input  pc, id_instr, id_pc4, id_valid, fault, fault_pc, fetch_count,
    output imem_do, stall, br_taken, br_target, jmp, jmp_index, jr, jr_target
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, redirect handling (jr > jmp > br),
// IF/ID capture with bubbles on redirect, and a sticky fault on illegal fetch addresses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 128
) (
  input  logic      clk,
  input  logic      rst,
  fetch_stage_if.master bus
);

  localparam logic [31:0] PC_MAX = IMEM_BYTES - 4;

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] cand;
  logic        illegal;

  always_comb begin
    seq_pc   = pc_q + 32'd4;
    redirect = bus.jr | bus.jmp | bus.br_taken;
    if (bus.jr)
      target = bus.jr_target;
    else if (bus.jmp)
      target = {pc4_q[31:28], bus.jmp_index, 2'b00};
    else
      target = bus.br_target;
    cand    = redirect ? target : seq_pc;
    illegal = (cand[1:0] != 2'b00) || (cand > PC_MAX);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (illegal) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = cand;
          end else begin
            pc_d = cand;
          end
        end else if (!bus.stall) begin
          // The current word is captured even when the next sequential pc faults.
          instr_d = bus.imem_do;
          pc4_d   = seq_pc;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          if (illegal) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = cand;
          end else begin
            pc_d = cand;
          end
        end
      end
      FAULT: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_pc4      = pc4_q;
  assign bus.id_valid    = valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirects, priority,
// fault entry and reset recovery, with hand-computed expectations.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [32];
  assign bus.imem_do = mem[bus.pc[6:2]];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.jmp = 1'b0; bus.jr = 1'b0;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
    chk({tag, ".pc"},    bus.pc,          pc);
    chk({tag, ".instr"}, bus.id_instr,    instr);
    chk({tag, ".pc4"},   bus.id_pc4,      pc4);
    chk({tag, ".valid"}, {31'b0, bus.id_valid}, {31'b0, valid});
    chk({tag, ".count"}, bus.fetch_count, cnt);
  endtask

  task automatic chk_fault(input string tag, input logic f, input logic [31:0] fpc);
    chk({tag, ".fault"},    {31'b0, bus.fault}, {31'b0, f});
    chk({tag, ".fault_pc"}, bus.fault_pc,       fpc);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h2400_0000 + i;
    mem[0] = 32'h3c01_0000;
    mem[1] = 32'h3424_0050;
    bus.br_target = '0; bus.jmp_index = '0; bus.jr_target = '0;
    idle();

    // reset
    rst = 1'b1;
    step(); step();
    chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk_fault("reset", 1'b0, 32'h0);

    // sequential fetch
    rst = 1'b0;
    step(); chk_if("seq1", 32'h4, 32'h3c01_0000, 32'h4, 1'b1, 32'd1);
    step(); chk_if("seq2", 32'h8, 32'h3424_0050, 32'h8, 1'b1, 32'd2);
    step(); step();
    chk_if("seq4", 32'h10, 32'h2400_0003, 32'h10, 1'b1, 32'd4);

    // stall three cycles at pc=0x10
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if("stall", 32'h10, 32'h2400_0003, 32'h10, 1'b1, 32'd4);
    end
    bus.stall = 1'b0;
    step(); chk_if("unstall", 32'h14, 32'h2400_0004, 32'h14, 1'b1, 32'd5);

    // jump: {0x0, 0x18, 00} = 0x60
    bus.jmp = 1'b1; bus.jmp_index = 26'h18;
    step(); chk_if("jmp", 32'h60, 32'h0, 32'h0, 1'b0, 32'd5);
    idle();

    // branch beats stall
    bus.br_taken = 1'b1; bus.br_target = 32'h64; bus.stall = 1'b1;
    step(); chk_if("br_stall", 32'h64, 32'h0, 32'h0, 1'b0, 32'd5);
    idle();
    step(); chk_if("br_fetch", 32'h68, 32'h2400_0019, 32'h68, 1'b1, 32'd6);

    // priority jr > jmp > br
    bus.jr = 1'b1; bus.jr_target = 32'h10;
    bus.jmp = 1'b1; bus.jmp_index = 26'h18;
    bus.br_taken = 1'b1; bus.br_target = 32'h64;
    step(); chk_if("prio", 32'h10, 32'h0, 32'h0, 1'b0, 32'd6);
    idle();
    step(); chk_if("prio_fetch", 32'h14, 32'h2400_0004, 32'h14, 1'b1, 32'd7);

    // misaligned jr target
    bus.jr = 1'b1; bus.jr_target = 32'h12;
    step(); chk_if("jr_mis", 32'h14, 32'h0, 32'h0, 1'b0, 32'd7);
    chk_fault("jr_mis", 1'b1, 32'h12);
    idle();
    bus.br_taken = 1'b1; bus.br_target = 32'h20;
    step(); chk_if("fault_hold", 32'h14, 32'h0, 32'h0, 1'b0, 32'd7);
    chk_fault("fault_hold", 1'b1, 32'h12);
    idle();

    // reset from FAULT
    rst = 1'b1;
    step(); chk_if("rst_fault", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk_fault("rst_fault", 1'b0, 32'h0);
    rst = 1'b0;
    step(); chk_if("restart", 32'h4, 32'h3c01_0000, 32'h4, 1'b1, 32'd1);

    // run off the end of memory
    bus.jr = 1'b1; bus.jr_target = 32'h74;
    step(); chk_if("jr74", 32'h74, 32'h0, 32'h0, 1'b0, 32'd1);
    idle();
    step(); chk_if("pc78", 32'h78, 32'h2400_001d, 32'h78, 1'b1, 32'd2);
    step(); chk_if("pc7c", 32'h7c, 32'h2400_001e, 32'h7c, 1'b1, 32'd3);
    chk_fault("pc7c", 1'b0, 32'h0);
    step(); chk_if("end_cap", 32'h7c, 32'h2400_001f, 32'h80, 1'b1, 32'd4);
    chk_fault("end_cap", 1'b1, 32'h80);
    step(); chk_if("end_bub", 32'h7c, 32'h0, 32'h0, 1'b0, 32'd4);
    chk_fault("end_bub", 1'b1, 32'h80);

    // reset during a stall
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    chk_if("pre_stall", 32'h8, 32'h3424_0050, 32'h8, 1'b1, 32'd2);
    bus.stall = 1'b1;
    step(); chk_if("stall2", 32'h8, 32'h3424_0050, 32'h8, 1'b1, 32'd2);
    rst = 1'b1;
    step(); chk_if("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk_fault("rst_stall", 1'b0, 32'h0);
    rst = 1'b0; bus.stall = 1'b0;
    step(); chk_if("restart2", 32'h4, 32'h3c01_0000, 32'h4, 1'b1, 32'd1);

    // out-of-range branch target
    bus.br_taken = 1'b1; bus.br_target = 32'h100;
    step(); chk_if("br_oor", 32'h4, 32'h0, 32'h0, 1'b0, 32'd1);
    chk_fault("br_oor", 1'b1, 32'h100);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
